// File: rtl/bus_request_unit_pkg.sv
// Shared types for the two-channel bus request unit: FSM states and grant encoding.
package bus_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  // One-hot grant vector layout used between arbiter and top level.
  localparam int GNT_FETCH_BIT = 0;
  localparam int GNT_DATA_BIT  = 1;

endpackage

// File: rtl/bus_request_unit_if.sv
// Memory-bus side of the request unit: strobes, address, write data and byte selects out, read data and busy back.
interface bus_request_unit_if #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int SEL_W  = DATA_W / 8
);

  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] cpu_dat_i;
  logic [SEL_W-1:0]  sel_i;
  logic [DATA_W-1:0] cpu_dat_o;
  logic              busy_o;

  modport master (
    output read_i, write_i, adr_i, cpu_dat_i, sel_i,
    input  cpu_dat_o, busy_o
  );

  modport slave (
    input  read_i, write_i, adr_i, cpu_dat_i, sel_i,
    output cpu_dat_o, busy_o
  );

endinterface

// File: rtl/bus_request_unit_arbiter.sv
// Two-way round-robin arbiter: when both channels request, the one not served last wins.
module req_rr_arbiter
  import bus_req_pkg::*;
(
  input  logic       req_fetch,
  input  logic       req_data,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req_fetch && req_data) begin
      if (last_grant == GNT_DATA) gnt[GNT_FETCH_BIT] = 1'b1;
      else                        gnt[GNT_DATA_BIT]  = 1'b1;
    end else if (req_fetch) begin
      gnt[GNT_FETCH_BIT] = 1'b1;
    end else if (req_data) begin
      gnt[GNT_DATA_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_request_unit.sv
// Arbitrates instruction-fetch and data load/store channels onto one memory bus
// through an IDLE -> REQ -> WAIT handshake with registered bus outputs and return data.
module bus_request_unit
  import bus_req_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_adr,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,

  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_adr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [SEL_W-1:0]  dmem_be,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,

  output logic              stall_o,

  bus_request_unit_if.master bus
);

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  grant_e            last_q, last_d;
  logic              op_wr_q, op_wr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              irdy_q, irdy_d;
  logic              drdy_q, drdy_d;

  logic              fetch_pend;
  logic              data_pend;
  logic [1:0]        gnt;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(SEL_W - 1);
  endfunction

  // A channel whose ready is pulsing this cycle still shows its old level request;
  // masking it keeps the same transaction from being issued twice.
  assign fetch_pend = imem_req & ~irdy_q;
  assign data_pend  = (dmem_read | dmem_write) & ~drdy_q;

  req_rr_arbiter u_arb (
    .req_fetch  (fetch_pend),
    .req_data   (data_pend),
    .last_grant (last_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    op_wr_d  = op_wr_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    irdy_d   = 1'b0;
    drdy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.busy_o && (gnt != 2'b00)) begin
          state_d = REQ;
          if (gnt[GNT_FETCH_BIT]) begin
            gnt_d   = GNT_FETCH;
            op_wr_d = 1'b0;
            read_d  = 1'b1;
            adr_d   = word_align(imem_adr);
            sel_d   = '1;
          end else begin
            gnt_d = GNT_DATA;
            adr_d = word_align(dmem_adr);
            // A simultaneous read and write is served as a store only.
            if (dmem_write) begin
              op_wr_d = 1'b1;
              write_d = 1'b1;
              sel_d   = dmem_be;
              wdat_d  = dmem_wdata;
            end else begin
              op_wr_d = 1'b0;
              read_d  = 1'b1;
              sel_d   = '1;
            end
          end
        end
      end

      REQ: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (!bus.busy_o) begin
          state_d = IDLE;
          last_d  = gnt_q;
          if (gnt_q == GNT_FETCH) begin
            irdata_d = bus.cpu_dat_o;
            irdy_d   = 1'b1;
          end else begin
            if (!op_wr_q) drdata_d = bus.cpu_dat_o;
            drdy_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_FETCH;
      last_q   <= GNT_DATA;
      op_wr_q  <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      irdy_q   <= 1'b0;
      drdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      op_wr_q  <= op_wr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      irdy_q   <= irdy_d;
      drdy_q   <= drdy_d;
    end
  end

  assign bus.read_i    = read_q;
  assign bus.write_i   = write_q;
  assign bus.adr_i     = adr_q;
  assign bus.cpu_dat_i = wdat_q;
  assign bus.sel_i     = sel_q;

  assign imem_rdata = irdata_q;
  assign imem_ready = irdy_q;
  assign dmem_rdata = drdata_q;
  assign dmem_ready = drdy_q;

  assign stall_o = ((dmem_read | dmem_write) & ~drdy_q) | (imem_req & ~irdy_q);

endmodule

// File: tb/tb_bus_request_unit.sv
// Directed bench for bus_request_unit: a vector table of single transactions plus
// hand-written contention, busy-hold, dropped-request and reset-mid-WAIT sequences.
module tb_bus_request_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_adr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ready;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] dmem_adr;
  logic [DW-1:0] dmem_wdata;
  logic [SW-1:0] dmem_be;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready;
  logic          stall_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_request_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_request_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_adr   (imem_adr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_adr   (dmem_adr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .stall_o    (stall_o),
    .bus        (bus)
  );

  // Bus model: after a strobe the bus stays busy for busy_lat cycles.
  int          busy_lat;
  logic        force_busy;
  int          cnt;
  logic [31:0] rdval;

  assign bus.busy_o    = (cnt != 0) | force_busy;
  assign bus.cpu_dat_o = rdval;

  always @(posedge clk or negedge rst) begin
    if (!rst)                          cnt <= 0;
    else if (bus.read_i | bus.write_i) cnt <= busy_lat;
    else if (cnt != 0)                 cnt <= cnt - 1;
  end

  // Strobe log, one entry per strobe cycle.
  logic [31:0] log_adr [64];
  logic [31:0] log_dat [64];
  logic [3:0]  log_sel [64];
  logic        log_wr  [64];
  int          n_str = 0;

  always @(posedge clk) begin
    if (bus.read_i | bus.write_i) begin
      if (n_str < 64) begin
        log_adr[n_str] <= bus.adr_i;
        log_dat[n_str] <= bus.cpu_dat_i;
        log_sel[n_str] <= bus.sel_i;
        log_wr[n_str]  <= bus.write_i;
      end
      n_str <= n_str + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ch;      // 0 fetch, 1 load, 2 store, 3 read+write together
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          busy;
    logic [31:0] rdv;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_wr;
    logic [31:0] e_dat;
    logic [31:0] e_i;
    logic [31:0] e_d;
  } vec_t;

  vec_t vt [8];

  task automatic drop_all();
    imem_req   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int   s0;
    int   cyc;
    logic got;
    s0       = n_str;
    busy_lat = v.busy;
    rdval    = v.rdv;
    case (v.ch)
      0: begin imem_req = 1'b1; imem_adr = v.adr; end
      1: begin dmem_read = 1'b1; dmem_adr = v.adr; end
      default: begin
        dmem_write = 1'b1;
        dmem_read  = (v.ch == 3);
        dmem_adr   = v.adr;
        dmem_wdata = v.wdata;
        dmem_be    = v.be;
      end
    endcase
    #1 chk({tag, " stall_pending"}, 32'(stall_o), 32'd1);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      got = (v.ch == 0) ? imem_ready : dmem_ready;
      chk({tag, " other_ready"}, 32'((v.ch == 0) ? dmem_ready : imem_ready), 32'd0);
    end
    chk({tag, " latency"}, 32'(cyc), 32'(3 + v.busy));
    chk({tag, " strobe_count"}, 32'(n_str - s0), 32'd1);
    if (s0 < 64) begin
      chk({tag, " adr_i"}, log_adr[s0], v.e_adr);
      chk({tag, " sel_i"}, 32'(log_sel[s0]), 32'(v.e_sel));
      chk({tag, " write_strobe"}, 32'(log_wr[s0]), 32'(v.e_wr));
      chk({tag, " cpu_dat_i"}, log_dat[s0], v.e_dat);
    end
    chk({tag, " imem_rdata"}, imem_rdata, v.e_i);
    chk({tag, " dmem_rdata"}, dmem_rdata, v.e_d);
    drop_all();
    #1 chk({tag, " stall_idle"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    chk({tag, " ready_one_cycle"}, 32'(imem_ready | dmem_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int   s0;
    int   cyc;
    int   nf;
    int   nd;
    logic got;
    vec_t v;

    //          ch adr            wdata          be    bsy rdv            e_adr          e_sel e_wr  e_dat          e_i            e_d
    vt[0] = '{0, 32'h0000_0104, 32'h0,         4'h0, 2, 32'h0051_0513, 32'h0000_0104, 4'hF, 1'b0, 32'h0,         32'h0051_0513, 32'h0};
    vt[1] = '{2, 32'h0000_0203, 32'hAABB_CCDD, 4'h8, 2, 32'hFFFF_0000, 32'h0000_0200, 4'h8, 1'b1, 32'hAABB_CCDD, 32'h0051_0513, 32'h0};
    vt[2] = '{1, 32'h0000_0010, 32'h0,         4'h0, 0, 32'h1111_1111, 32'h0000_0010, 4'hF, 1'b0, 32'hAABB_CCDD, 32'h0051_0513, 32'h1111_1111};
    vt[3] = '{1, 32'h0000_0014, 32'h0,         4'h0, 0, 32'h2222_3333, 32'h0000_0014, 4'hF, 1'b0, 32'hAABB_CCDD, 32'h0051_0513, 32'h2222_3333};
    vt[4] = '{2, 32'h0000_0007, 32'h1234_5678, 4'h0, 1, 32'hFFFF_0000, 32'h0000_0004, 4'h0, 1'b1, 32'h1234_5678, 32'h0051_0513, 32'h2222_3333};
    vt[5] = '{3, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 0, 32'h9999_9999, 32'h0000_0030, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0051_0513, 32'h2222_3333};
    vt[6] = '{0, 32'h0000_03FF, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 32'h0000_03FC, 4'hF, 1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h2222_3333};
    vt[7] = '{1, 32'h0000_0042, 32'h0,         4'h0, 1, 32'h0BAD_C0DE, 32'h0000_0040, 4'hF, 1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0BAD_C0DE};

    rst        = 1'b0;
    force_busy = 1'b0;
    busy_lat   = 0;
    rdval      = '0;
    imem_adr   = '0;
    dmem_adr   = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    drop_all();
    repeat (3) @(negedge clk);
    chk("reset read_i", 32'(bus.read_i), 32'd0);
    chk("reset write_i", 32'(bus.write_i), 32'd0);
    chk("reset adr_i", bus.adr_i, 32'd0);
    chk("reset sel_i", 32'(bus.sel_i), 32'd0);
    chk("reset readies", 32'({imem_ready, dmem_ready}), 32'd0);
    chk("reset stall_o", 32'(stall_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i]);
    end

    // Contention: both channels held, FETCH must go first and grants alternate.
    s0 = n_str;
    nf = 0;
    nd = 0;
    busy_lat = 1;
    rdval    = 32'h0C0C_0C0C;
    imem_req = 1'b1; imem_adr = 32'h100;
    dmem_read = 1'b1; dmem_adr = 32'h200;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (imem_ready) nf++;
      if (dmem_ready) nd++;
    end
    drop_all();
    repeat (10) @(negedge clk);
    chk("cont grant_count", 32'(n_str - s0 >= 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (s0 + k < 64)
        chk($sformatf("cont grant%0d", k), log_adr[s0+k], (k % 2 == 0) ? 32'h100 : 32'h200);
    end
    chk("cont fetch_served", 32'(nf >= 2), 32'd1);
    chk("cont data_served", 32'(nd >= 2), 32'd1);

    // Busy at request: no strobe until busy_o falls, then strobe one cycle later.
    s0 = n_str;
    force_busy = 1'b1;
    busy_lat   = 0;
    rdval      = 32'h5555_0000;
    imem_req   = 1'b1; imem_adr = 32'h500;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("busy hold_read_i", 32'(bus.read_i), 32'd0);
    end
    chk("busy no_strobe", 32'(n_str - s0), 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy release_read_i", 32'(bus.read_i), 32'd1);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = imem_ready;
    end
    chk("busy ready_seen", 32'(got), 32'd1);
    chk("busy imem_rdata", imem_rdata, 32'h5555_0000);
    drop_all();
    @(negedge clk);

    // Request dropped in WAIT: transaction still completes and data is captured.
    busy_lat = 3;
    rdval    = 32'h600D_F00D;
    imem_req = 1'b1; imem_adr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    imem_req = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = imem_ready;
    end
    chk("drop ready_seen", 32'(got), 32'd1);
    chk("drop imem_rdata", imem_rdata, 32'h600D_F00D);
    @(negedge clk);

    // Reset in WAIT: everything clears at once, no late ready afterwards.
    busy_lat = 5;
    rdval    = 32'h7777_7777;
    imem_req = 1'b1; imem_adr = 32'h600;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drop_all();
    #1;
    chk("rstwait read_i", 32'(bus.read_i | bus.write_i), 32'd0);
    chk("rstwait adr_i", bus.adr_i, 32'd0);
    chk("rstwait cpu_dat_i", bus.cpu_dat_i, 32'd0);
    chk("rstwait sel_i", 32'(bus.sel_i), 32'd0);
    chk("rstwait imem_rdata", imem_rdata, 32'd0);
    chk("rstwait dmem_rdata", dmem_rdata, 32'd0);
    chk("rstwait readies", 32'({imem_ready, dmem_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstwait no_spurious_ready", 32'(imem_ready | dmem_ready), 32'd0);
    end
    v = '{1, 32'h0000_0080, 32'h0, 4'h0, 0, 32'h1357_2468, 32'h0000_0080, 4'hF, 1'b0, 32'h0, 32'h0, 32'h1357_2468};
    run_txn("after_reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
